// File: rtl/vga_pkg.sv
// Shared types and 640x480 defaults for the framebuffer arbiter.
`default_nettype none
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CPU     = 2'd2,
    CPU_ACK = 2'd3
  } arb_state_t;

  localparam int VGA_LINE_WORDS = 320;
  localparam int VGA_V_LINES    = 480;

endpackage
`default_nettype wire

// File: rtl/vga_line_fetch_ctr.sv
// Line-fetch counters: word index, line base address, line count and write bank.
`default_nettype none
module vga_line_fetch_ctr #(
  parameter int ADDR_W     = 19,
  parameter int LB_AW      = 9,
  parameter int LINE_WORDS = 320,
  parameter int V_LINES    = 480,
  parameter int FB_BASE    = 0,
  parameter int CNT_W      = 9
) (
  input  logic              clock,
  input  logic              rst_i,
  input  logic              start,
  input  logic              advance,
  input  logic              frame_reset,
  input  logic              restart_fetch,
  output logic [LB_AW-1:0]  word,
  output logic [ADDR_W-1:0] line_base,
  output logic [CNT_W-1:0]  line_cnt,
  output logic              wr_bank,
  output logic              last_word,
  output logic              line_done,
  output logic [ADDR_W-1:0] fetch_adr
);

  assign last_word = (word == LB_AW'(LINE_WORDS - 1));
  assign line_done = advance & last_word & ~restart_fetch;
  assign fetch_adr = line_base + ADDR_W'(word);

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      word      <= '0;
      line_base <= ADDR_W'(FB_BASE);
      line_cnt  <= '0;
      wr_bank   <= 1'b0;
    end else begin
      // A frame restart discards the partial line and keeps the current bank
      if (restart_fetch) begin
        word      <= '0;
        line_base <= ADDR_W'(FB_BASE);
        line_cnt  <= '0;
      end else if (advance) begin
        if (last_word) begin
          word      <= '0;
          wr_bank   <= ~wr_bank;
          line_base <= line_base + ADDR_W'(LINE_WORDS);
          if (line_cnt < CNT_W'(V_LINES))
            line_cnt <= line_cnt + CNT_W'(1);
        end else begin
          word <= word + LB_AW'(1);
        end
      end else if (start) begin
        word <= '0;
      end
      if (frame_reset) begin
        line_base <= ADDR_W'(FB_BASE);
        line_cnt  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: scan-out line fetch (priority) and Wishbone CPU share one memory port.
`default_nettype none
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = VGA_LINE_WORDS,
  parameter int V_LINES    = VGA_V_LINES,
  parameter int FB_BASE    = 0,
  parameter int LB_AW      = 9
) (
  input  logic              clock,
  input  logic              rst_i,
  input  logic              eol,
  input  logic              eos,
  input  logic              v_active,
  input  logic              cpu_cyc_i,
  input  logic              cpu_stb_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_adr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  output logic [DATA_W-1:0] cpu_dat_o,
  output logic              cpu_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [DATA_W-1:0] mem_dat_o,
  input  logic [DATA_W-1:0] mem_dat_i,
  input  logic              mem_ack_i,
  output logic              lb_we_o,
  output logic [LB_AW:0]    lb_adr_o,
  output logic [DATA_W-1:0] lb_dat_o,
  output logic              lb_rd_bank_o,
  output logic              underrun_o
);

  localparam int CNT_W = $clog2(V_LINES + 1);

  arb_state_t state, state_nxt;
  logic              pend, restart_pend;
  logic [ADDR_W-1:0] cpu_adr_q;
  logic [DATA_W-1:0] cpu_wdat_q;
  logic              cpu_we_q;

  logic [LB_AW-1:0]  word;
  logic [ADDR_W-1:0] line_base, fetch_adr;
  logic [CNT_W-1:0]  line_cnt;
  logic              wr_bank, last_word, line_done;

  logic fetch_ack, start, restart, eol_trig, overrun, frame_reset, take, cpu_start;

  assign fetch_ack   = (state == FETCH) & mem_ack_i;
  assign start       = (state == IDLE) & pend;
  assign restart     = fetch_ack & (restart_pend | eos);
  assign eol_trig    = eol & v_active & (line_cnt < CNT_W'(V_LINES)) & ~eos;
  assign overrun     = eol_trig & (pend | (state == FETCH));
  assign frame_reset = eos & (state != FETCH);
  assign take        = start | (line_done & pend);
  assign cpu_start   = (state == IDLE) & ~pend & cpu_cyc_i & cpu_stb_i;

  vga_line_fetch_ctr #(
    .ADDR_W(ADDR_W), .LB_AW(LB_AW), .LINE_WORDS(LINE_WORDS),
    .V_LINES(V_LINES), .FB_BASE(FB_BASE), .CNT_W(CNT_W)
  ) u_ctr (
    .clock(clock), .rst_i(rst_i), .start(start), .advance(fetch_ack),
    .frame_reset(frame_reset), .restart_fetch(restart),
    .word(word), .line_base(line_base), .line_cnt(line_cnt), .wr_bank(wr_bank),
    .last_word(last_word), .line_done(line_done), .fetch_adr(fetch_adr)
  );

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend) state_nxt = FETCH;
               else if (cpu_cyc_i & cpu_stb_i) state_nxt = CPU;
      FETCH:   if (line_done) state_nxt = pend ? FETCH : IDLE;
      CPU:     if (mem_ack_i) state_nxt = CPU_ACK;
      CPU_ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    cpu_ack_o = 1'b0;
    case (state)
      FETCH: begin
        mem_req_o = 1'b1;
        mem_adr_o = fetch_adr;
      end
      CPU: begin
        mem_req_o = 1'b1;
        mem_we_o  = cpu_we_q;
        mem_adr_o = cpu_adr_q;
        mem_dat_o = cpu_wdat_q;
      end
      CPU_ACK: cpu_ack_o = 1'b1;
      default: ;
    endcase
  end

  // eos while fetching is deferred to the in-flight word's ack instead of pending a new line
  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      pend         <= 1'b0;
      restart_pend <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      underrun_o <= overrun;
      if (take) pend <= 1'b0;
      if ((frame_reset & ~start) | (eol_trig & ~overrun)) pend <= 1'b1;
      if (eos & (state == FETCH)) pend <= 1'b0;
      if (restart) restart_pend <= 1'b0;
      else if (eos & (state == FETCH)) restart_pend <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      cpu_adr_q  <= '0;
      cpu_wdat_q <= '0;
      cpu_we_q   <= 1'b0;
      cpu_dat_o  <= '0;
    end else begin
      if (cpu_start) begin
        cpu_adr_q  <= cpu_adr_i;
        cpu_wdat_q <= cpu_dat_i;
        cpu_we_q   <= cpu_we_i;
      end
      if ((state == CPU) & mem_ack_i & ~cpu_we_q) cpu_dat_o <= mem_dat_i;
    end
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      lb_we_o      <= 1'b0;
      lb_adr_o     <= '0;
      lb_dat_o     <= '0;
      lb_rd_bank_o <= 1'b0;
    end else begin
      lb_we_o <= fetch_ack;
      if (fetch_ack) begin
        lb_adr_o <= {wr_bank, word};
        lb_dat_o <= mem_dat_i;
      end
      if (line_done) lb_rd_bank_o <= wr_bank;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter.
`default_nettype none
module tb_vga_fb_arbiter;

  logic        clock = 1'b0;
  logic        rst_i, eol, eos, v_active;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [18:0] cpu_adr_i;
  logic [15:0] cpu_dat_i, cpu_dat_o;
  logic        cpu_ack_o, mem_req_o, mem_we_o;
  logic [18:0] mem_adr_o;
  logic [15:0] mem_dat_o, mem_dat_i;
  logic        mem_ack_i;
  logic        lb_we_o;
  logic [9:0]  lb_adr_o;
  logic [15:0] lb_dat_o;
  logic        lb_rd_bank_o, underrun_o;

  logic        ack_auto, ack_man;
  logic [15:0] cpu_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  assign mem_ack_i = ack_auto ? mem_req_o : ack_man;
  assign mem_dat_i = ack_auto ? (mem_adr_o[15:0] ^ 16'h5A5A) : cpu_rdata;

  vga_fb_arbiter u_dut (
    .clock(clock), .rst_i(rst_i), .eol(eol), .eos(eos), .v_active(v_active),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o),
    .cpu_ack_o(cpu_ack_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_ack_i(mem_ack_i), .lb_we_o(lb_we_o), .lb_adr_o(lb_adr_o),
    .lb_dat_o(lb_dat_o), .lb_rd_bank_o(lb_rd_bank_o), .underrun_o(underrun_o)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Zero-wait line fetch from base into bank; optional eol injected at word eol_at
  task automatic run_fetch(input int base, input int bank, input int eol_at);
    int waited = 0;
    int ur = 0;
    while (!mem_req_o && waited < 2) begin
      tick;
      waited++;
    end
    check("fetch_start", {31'd0, mem_req_o}, 32'd1);
    if (!mem_req_o) return;
    for (int i = 0; i < 320; i++) begin
      check("fetch_adr", {13'd0, mem_adr_o}, base + i);
      check("fetch_we", {31'd0, mem_we_o}, 32'd0);
      if (i > 0) begin
        check("lb_we", {31'd0, lb_we_o}, 32'd1);
        check("lb_adr", {22'd0, lb_adr_o}, bank * 512 + i - 1);
        check("lb_dat", {16'd0, lb_dat_o}, ((base + i - 1) & 16'hFFFF) ^ 16'h5A5A);
      end
      if (i == eol_at) eol = 1'b1;
      tick;
      eol = 1'b0;
      if (underrun_o) ur++;
    end
    check("lb_adr_last", {22'd0, lb_adr_o}, bank * 512 + 319);
    check("lb_we_last", {31'd0, lb_we_o}, 32'd1);
    check("lb_rd_bank", {31'd0, lb_rd_bank_o}, bank);
    check("req_after_line", {31'd0, mem_req_o}, 32'd0);
    check("underrun_cnt", ur, (eol_at >= 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int extra;
    rst_i = 1'b1; eol = 1'b0; eos = 1'b0; v_active = 1'b0;
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
    cpu_adr_i = '0; cpu_dat_i = '0;
    ack_auto = 1'b0; ack_man = 1'b0; cpu_rdata = '0;
    tick; tick;
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_lb_bank", {31'd0, lb_rd_bank_o}, 32'd0);
    check("rst_cpu_ack", {31'd0, cpu_ack_o}, 32'd0);
    rst_i = 1'b0;
    v_active = 1'b1;
    tick;

    // Line 0 after eos, bank 0
    ack_auto = 1'b1;
    eos = 1'b1; tick; eos = 1'b0;
    run_fetch(0, 0, -1);

    // Line 1 after eol, bank 1
    eol = 1'b1; tick; eol = 1'b0;
    run_fetch(320, 1, -1);

    // CPU read, memory answers 0xBEEF in the second request cycle
    ack_auto = 1'b0;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 19'h01234;
    tick;
    check("cpu_rd_req", {31'd0, mem_req_o}, 32'd1);
    check("cpu_rd_adr", {13'd0, mem_adr_o}, 32'h1234);
    check("cpu_rd_we", {31'd0, mem_we_o}, 32'd0);
    tick;
    check("cpu_ack_early", {31'd0, cpu_ack_o}, 32'd0);
    ack_man = 1'b1; cpu_rdata = 16'hBEEF;
    tick;
    ack_man = 1'b0;
    check("cpu_rd_ack", {31'd0, cpu_ack_o}, 32'd1);
    check("cpu_rd_dat", {16'd0, cpu_dat_o}, 32'hBEEF);
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    tick;
    check("cpu_ack_pulse", {31'd0, cpu_ack_o}, 32'd0);
    check("cpu_dat_hold", {16'd0, cpu_dat_o}, 32'hBEEF);

    // CPU write in flight when eol arrives; fetch follows the write
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b1;
    cpu_adr_i = 19'h00100; cpu_dat_i = 16'hCAFE;
    tick;
    check("cpu_wr_we", {31'd0, mem_we_o}, 32'd1);
    check("cpu_wr_adr", {13'd0, mem_adr_o}, 32'h100);
    check("cpu_wr_dat", {16'd0, mem_dat_o}, 32'hCAFE);
    eol = 1'b1; tick; eol = 1'b0;
    check("cpu_wr_hold", {31'd0, mem_req_o & mem_we_o}, 32'd1);
    check("no_underrun_cpu", {31'd0, underrun_o}, 32'd0);
    ack_man = 1'b1;
    tick;
    ack_man = 1'b0;
    check("cpu_wr_ack", {31'd0, cpu_ack_o}, 32'd1);
    check("cpu_ack_no_req", {31'd0, mem_req_o}, 32'd0);
    check("cpu_wr_keeps_rd", {16'd0, cpu_dat_o}, 32'hBEEF);
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
    ack_auto = 1'b1;
    // Line 2 with an overrun eol at word 10
    run_fetch(640, 0, 10);

    extra = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (mem_req_o) extra++;
    end
    check("no_extra_fetch", extra, 0);

    // Line 3 must still start at 960: the dropped eol did not advance anything
    eol = 1'b1; tick; eol = 1'b0;
    run_fetch(960, 1, -1);

    // Line 4: eos at word 100 restarts the frame at address 0
    eol = 1'b1; tick; eol = 1'b0;
    tick;
    check("l4_start", {31'd0, mem_req_o}, 32'd1);
    for (int i = 0; i <= 100; i++) begin
      if (mem_adr_o != 19'(1280 + i)) check("l4_adr", {13'd0, mem_adr_o}, 1280 + i);
      if (i == 100) eos = 1'b1;
      tick;
      eos = 1'b0;
    end
    check("eos_restart_adr", {13'd0, mem_adr_o}, 32'd0);
    check("eos_restart_req", {31'd0, mem_req_o}, 32'd1);
    check("eos_last_lb", {22'd0, lb_adr_o}, 32'd100);
    check("eos_rd_bank", {31'd0, lb_rd_bank_o}, 32'd1);
    check("eos_no_underrun", {31'd0, underrun_o}, 32'd0);
    for (int k = 0; k < 5; k++) tick;
    check("eos_word5", {13'd0, mem_adr_o}, 32'd5);
    check("eos_lb_bank0", {22'd0, lb_adr_o}, 32'd4);

    // Asynchronous reset mid-burst, sampled before the next clock edge
    #2 rst_i = 1'b1;
    #1;
    check("arst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("arst_mem_adr", {13'd0, mem_adr_o}, 32'd0);
    check("arst_lb_we", {31'd0, lb_we_o}, 32'd0);
    check("arst_lb_adr", {22'd0, lb_adr_o}, 32'd0);
    check("arst_lb_bank", {31'd0, lb_rd_bank_o}, 32'd0);
    check("arst_cpu_dat", {16'd0, cpu_dat_o}, 32'd0);
    check("arst_cpu_ack", {31'd0, cpu_ack_o}, 32'd0);
    tick; tick;
    rst_i = 1'b0;
    tick;
    check("post_rst_idle", {31'd0, mem_req_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer memory arbiter and line-fetch scheduler for the 640x480 display path. It shares one single-port video memory between two users: the scan-out line fetcher, which always has priority, and a Wishbone-classic CPU port. Line fetches are triggered from the timing generator's `eol`/`eos`/`v_active` strobes and written into a double-banked line buffer that the pixel pipeline reads on the next line.

## Interface
Parameters:
- `ADDR_W`, 19: memory word-address width.
- `DATA_W`, 16: memory and CPU data width.
- `LINE_WORDS`, 320: words fetched per display line.
- `V_LINES`, 480: lines fetched per frame.
- `FB_BASE`, 0: word address of line 0.
- `LB_AW`, 9: line-buffer word-index width, with `2**LB_AW >= LINE_WORDS`.

Ports:
- `clock`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `eol`, in, 1: end-of-line strobe, 1 cycle wide.
- `eos`, in, 1: end-of-screen strobe, 1 cycle wide, coincident with an `eol`.
- `v_active`, in, 1: vertical active region.
- `cpu_cyc_i`, `cpu_stb_i`, `cpu_we_i`, in, 1 each: CPU cycle, strobe and write enable.
- `cpu_adr_i`, in, ADDR_W: CPU address.
- `cpu_dat_i`, in, DATA_W: CPU write data.
- `cpu_dat_o`, out, DATA_W: CPU read data, registered.
- `cpu_ack_o`, out, 1: CPU ack, 1-cycle pulse.
- `mem_req_o`, `mem_we_o`, out, 1 each: memory request and write enable.
- `mem_adr_o`, out, ADDR_W: memory address.
- `mem_dat_o`, out, DATA_W: memory write data.
- `mem_dat_i`, in, DATA_W: memory read data.
- `mem_ack_i`, in, 1: memory ack.
- `lb_we_o`, out, 1: line-buffer write enable.
- `lb_adr_o`, out, LB_AW+1: line-buffer address, {bank, word}.
- `lb_dat_o`, out, DATA_W: line-buffer write data.
- `lb_rd_bank_o`, out, 1: bank holding the most recently completed line.
- `underrun_o`, out, 1: 1-cycle pulse on a fetch overrun.

## Operation
- **States:** IDLE, FETCH, CPU, CPU_ACK.
- **Fetch trigger:**
  - `eos` sets `pend`, `line_cnt`=0 and `line_base`=FB_BASE.
  - `eol` with `v_active` and `line_cnt`<V_LINES sets `pend`.
  - `eos` takes precedence when both strobes coincide.
- **Overrun:** a trigger that arrives while `pend` is set or the state is FETCH is dropped, and `underrun_o` pulses. This does not apply to `eos`.
- **IDLE:**
  - `pend` → FETCH, clears `pend`, `word`=0.
  - Otherwise `cpu_cyc_i & cpu_stb_i` → CPU, latching address, data and write enable.
- **FETCH:**
  - Drives `mem_req_o`=1, `mem_we_o`=0, `mem_adr_o`=`line_base`+`word`.
  - On `mem_ack_i`: capture `mem_dat_i`; `word`++.
  - At `word`==LINE_WORDS-1 with ack:
    - toggle `wr_bank` and set `lb_rd_bank_o` to the bank just filled;
    - `line_base` += LINE_WORDS;
    - `line_cnt`++;
    - go to IDLE, or straight to FETCH if `pend` is set.
- **CPU:** holds `mem_req_o` with the latched fields until `mem_ack_i`, then goes to CPU_ACK.
- **CPU_ACK:**
  - `cpu_ack_o`=1 and `cpu_dat_o` holds the captured read data.
  - Next state is IDLE.
  - No new CPU access starts in this cycle.
- **Priority:** the fetcher has priority but never preempts a CPU access already issued to memory. Worst-case fetch start delay is one CPU memory latency plus 2 cycles.
- **`eos` during FETCH:** the in-flight word completes. At its ack the fetch restarts with `word`=0, `line_base`=FB_BASE, `line_cnt`=0. Bank is unchanged and no underrun is flagged.
- **Widths:** `line_base` and the address sum wrap modulo 2^ADDR_W. `line_cnt` saturates at V_LINES.
- **Reset values:** state IDLE; `pend`=0; every output 0; `wr_bank`=0; `lb_rd_bank_o`=0; counters 0; `line_base`=FB_BASE.

## Timing
- A trigger sampled at edge t gives `mem_req_o`=1 from cycle t+1 when the state is IDLE.
- `mem_ack_i` may assert in any cycle that `mem_req_o` is high, including the first.
- `mem_adr_o` advances the cycle after each ack, so `mem_req_o` stays high back-to-back across a burst.
- `lb_we_o`/`lb_adr_o`/`lb_dat_o` are registered: the write for a given ack occurs the cycle after that ack.
- A zero-wait fetch takes LINE_WORDS cycles plus 1 trailing line-buffer write.
- `cpu_ack_o` rises the cycle after the CPU `mem_ack_i`. The CPU must drop `cpu_stb_i` in the cycle `cpu_ack_o` is high.
- `lb_rd_bank_o` updates the cycle after the final ack, together with the final `lb_we_o`.

## Structure
- Shared `vga_pkg` holds:
  - `arb_state_t` enum (IDLE, FETCH, CPU, CPU_ACK);
  - 640x480 defaults: LINE_WORDS, V_LINES.
- One natural sub-module, `vga_line_fetch_ctr`, owning `word`, `line_base`, `line_cnt`, `wr_bank` and the restart/advance controls.
- The top level keeps the FSM, trigger logic and CPU path.

## Test plan
- **Zero-wait fetch:** reset; `eos`; `mem_ack_i` tied 1 → 320 consecutive reads at 0..319; `lb_adr_o` goes 0x000..0x13F; then `lb_rd_bank_o`=0 and `wr_bank`=1.
- **Second line:** `eol` with `v_active` after the first fetch → reads at 320..639; writes into bank 1 (`lb_adr_o` 0x200..0x33F); `lb_rd_bank_o`=1.
- **CPU read:** CPU read of 0x1234 in IDLE with memory returning 0xBEEF at 2-cycle latency → `cpu_ack_o` 1 cycle after `mem_ack_i`; `cpu_dat_o`=0xBEEF.
- **CPU then fetch:** CPU write in flight when `eol` arrives → write completes; `cpu_ack_o` pulses; FETCH begins the cycle after CPU_ACK.
- **Overrun:** `eol` during an active fetch → `underrun_o` pulses once; no extra line fetched; `line_cnt` unchanged.
- **`eos` mid-fetch and mid-operation reset:** `eos` at word 100 → the next request is address 0 with `word`=0. `rst_i` mid-burst → all outputs 0 immediately, without waiting for a clock.
